sort_chain_ctrl: RTL and testbench

Sequencer for a linear chain of `DEPTH` sort nodes used by the pairwise-distance top-K search. It clears the chain and streams candidate connections into it until the upstream marks the last one. It then lets the chain settle, issues the single read pulse and drains the sorted results through a small output buffer. Chain backpressure is handled by driving the nodes' forward-ready input.

---
 rtl/sort_chain_ctrl_if.sv | 19 +
 rtl/sort_chain_ctrl.sv | 157 +++++++++++++++
 tb/tb_sort_chain_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_chain_ctrl_if.sv
// Connection record shared with the sort nodes, plus the valid/ready/last
// stream interface used for both the candidate input and the result output.
package sort_chain_pkg;
   typedef struct packed {
      logic [15:0] distance;
      logic [9:0]  pointa;
      logic [9:0]  pointb;
   } conn_t;
endpackage

interface sort_chain_ctrl_if;
   import sort_chain_pkg::*;
   conn_t conn;
   logic  vld;
   logic  last;
   logic  rdy;
   modport master (output conn, vld, last, input rdy);
   modport slave  (input conn, vld, last, output rdy);
endinterface

// File: rtl/sort_chain_ctrl.sv
// Sequencer for a linear sort-node chain: clear, fill, settle, read pulse,
// then drain the sorted results through a small FWFT skid buffer.
module sort_chain_ctrl
   import sort_chain_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 20,
   parameter int SKID_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   sort_chain_ctrl_if.slave   i_in,
   sort_chain_ctrl_if.master  o_out,
   output logic               o_chain_rst_n,
   output conn_t              o_chain_conn,
   output logic               o_chain_vld,
   output logic               o_chain_read,
   output logic               o_chain_fwd_rdy,
   input  conn_t              i_chain_out_conn,
   input  logic               i_chain_out_vld,
   output logic               o_busy,
   output logic               o_done,
   output logic [CNT_W-1:0]   o_in_count
);
   localparam int TMR_W = $clog2(DEPTH + 2);
   localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int OCC_W = $clog2(SKID_DEPTH + 1);
   localparam int RES_W = $clog2(DEPTH + 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(SKID_DEPTH);
   localparam logic [OCC_W-1:0] OCC_HI      = OCC_W'(SKID_DEPTH - 2);
   localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(SKID_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_FILL, S_SETTLE, S_READ, S_DRAIN, S_DONE
   } state_t;

   state_t           r_state, w_nxt;
   logic [TMR_W-1:0] r_tmr;
   logic             r_chain_rst_n, r_chain_vld, r_fwd_rdy;
   conn_t            r_chain_conn;
   logic [CNT_W-1:0] r_cnt;
   conn_t            r_buf [SKID_DEPTH];
   logic [PTR_W-1:0] r_wp, r_rp;
   logic [OCC_W-1:0] r_occ;
   logic [RES_W-1:0] r_pushed, r_popped;
   logic [RES_W-1:0] w_exp;
   logic             w_in_rdy, w_acc, w_push, w_pop, w_last, w_final, w_job_clr;
   logic             w_busy, w_done, w_read;

   assign w_exp     = (r_cnt >= CNT_W'(DEPTH)) ? RES_W'(DEPTH) : RES_W'(r_cnt);
   assign w_acc     = w_in_rdy && i_in.vld;
   assign w_job_clr = (r_state == S_IDLE) && i_start;
   // Results beyond the expected count are dropped at the buffer input.
   assign w_push    = (r_state == S_DRAIN) && i_chain_out_vld && (r_pushed != w_exp);
   assign w_pop     = (r_occ != '0) && o_out.rdy;
   assign w_last    = (r_occ != '0) && ((r_popped + RES_W'(1)) == w_exp);
   assign w_final   = (r_state == S_DRAIN) && w_pop && w_last;

   always_comb begin
      w_nxt    = r_state;
      w_in_rdy = 1'b0;
      w_busy   = (r_state != S_IDLE);
      w_done   = 1'b0;
      w_read   = 1'b0;
      unique case (r_state)
         S_IDLE:   if (i_start) w_nxt = S_CLR;
         S_CLR:    if (r_tmr == TMR_W'(1)) w_nxt = S_FILL;
         S_FILL: begin
            w_in_rdy = 1'b1;
            if (w_acc && i_in.last) w_nxt = S_SETTLE;
         end
         S_SETTLE: if (r_tmr == SETTLE_LAST) w_nxt = S_READ;
         S_READ: begin
            w_read = 1'b1;
            w_nxt  = S_DRAIN;
         end
         S_DRAIN:  if (w_final) w_nxt = S_DONE;
         S_DONE: begin
            w_done = 1'b1;
            w_nxt  = S_IDLE;
         end
         default:  w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_tmr         <= '0;
         r_chain_rst_n <= 1'b0;
         r_chain_vld   <= 1'b0;
         r_chain_conn  <= '0;
         r_fwd_rdy     <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_nxt;
         r_tmr         <= (r_state != w_nxt) ? '0 : r_tmr + TMR_W'(1);
         r_chain_rst_n <= (w_nxt != S_CLR);
         r_chain_vld   <= w_acc;
         if (w_acc) r_chain_conn <= i_in.conn;
         // One-cycle lag on occupancy is covered by the two spare entries.
         r_fwd_rdy     <= (w_nxt == S_DRAIN) && (r_occ <= OCC_HI);
         if (w_job_clr)
            r_cnt <= '0;
         else if (w_acc && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_occ    <= '0;
         r_pushed <= '0;
         r_popped <= '0;
      end else if (w_job_clr) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_occ    <= '0;
         r_pushed <= '0;
         r_popped <= '0;
      end else begin
         if (w_push) begin
            r_wp     <= (r_wp == PTR_LAST) ? '0 : r_wp + PTR_W'(1);
            r_pushed <= r_pushed + RES_W'(1);
         end
         if (w_pop) begin
            r_rp     <= (r_rp == PTR_LAST) ? '0 : r_rp + PTR_W'(1);
            r_popped <= r_popped + RES_W'(1);
         end
         r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_buf[r_wp] <= i_chain_out_conn;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && (r_occ == OCC_FULL)));

   assign i_in.rdy        = w_in_rdy;
   assign o_out.conn      = r_buf[r_rp];
   assign o_out.vld       = (r_occ != '0);
   assign o_out.last      = w_last;
   assign o_chain_rst_n   = r_chain_rst_n;
   assign o_chain_conn    = r_chain_conn;
   assign o_chain_vld     = r_chain_vld;
   assign o_chain_read    = w_read;
   assign o_chain_fwd_rdy = r_fwd_rdy;
   assign o_busy          = w_busy;
   assign o_done          = w_done;
   assign o_in_count      = r_cnt;
endmodule

// File: tb/tb_sort_chain_ctrl.sv
// Bench for sort_chain_ctrl: a behavioural sort-chain model sits behind the
// DUT and a sorted top-K reference predicts every result.
module tb_sort_chain_ctrl;
   import sort_chain_pkg::*;
   localparam int DEPTH = 4;
   localparam int CNT_W = 20;
   localparam int SKID  = 4;
   typedef logic [$bits(conn_t)-1:0] cv_t;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   conn_t chain_conn, chain_out_conn;
   logic chain_rst_n, chain_vld, chain_read, chain_fwd_rdy, busy, done;
   logic chain_out_vld = 1'b0;
   logic [CNT_W-1:0] in_count;

   sort_chain_ctrl_if u_in ();
   sort_chain_ctrl_if u_out ();

   always #5 clk = ~clk;

   sort_chain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SKID_DEPTH(SKID)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start),
      .i_in(u_in), .o_out(u_out),
      .o_chain_rst_n(chain_rst_n), .o_chain_conn(chain_conn), .o_chain_vld(chain_vld),
      .o_chain_read(chain_read), .o_chain_fwd_rdy(chain_fwd_rdy),
      .i_chain_out_conn(chain_out_conn), .i_chain_out_vld(chain_out_vld),
      .o_busy(busy), .o_done(done), .o_in_count(in_count)
   );

   cv_t inq[$], expq[$], capq[$], emitq[$];
   int  checks = 0, errs = 0, cyc_n = 0;
   int  n_job, E, nout, npushed, occ, prev_occ, last_acc, done_cnt, rdy_mode;
   bit  in_drain, pend_done, prev_acc;
   cv_t prev_conn;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic cv_t mk(input int d);
      mk = {16'(d), 10'($urandom), 10'($urandom)};
   endfunction

   // One clock cycle: drive inputs and the chain model at the falling edge,
   // check this cycle's outputs, then book what the next rising edge does.
   task automatic cyc(input bit st);
      cv_t t[$];
      int  cur_occ;
      bit  acc;
      @(negedge clk);
      cyc_n++;
      start    = st;
      u_in.vld = (inq.size() > 0) && ($urandom_range(0, 3) != 0);
      u_in.conn = (inq.size() > 0) ? conn_t'(inq[0]) : '0;
      u_in.last = (inq.size() == 1);
      case (rdy_mode)
         0:       u_out.rdy = 1'b1;
         1:       u_out.rdy = ((cyc_n % 4) == 0) || ((cyc_n % 4) == 3);
         default: u_out.rdy = 1'($urandom_range(0, 1));
      endcase
      if (chain_fwd_rdy && (emitq.size() > 0) && ($urandom_range(0, 4) != 0)) begin
         chain_out_vld  = 1'b1;
         chain_out_conn = conn_t'(emitq[0]);
      end else begin
         chain_out_vld  = 1'b0;
         chain_out_conn = conn_t'(cv_t'($urandom));
      end

      chk("chain_vld", chain_vld, prev_acc);
      if (prev_acc) chk("chain_conn", chain_conn, prev_conn);
      chk("done", done, pend_done);
      if (in_drain) begin
         chk("fwd_rdy", chain_fwd_rdy, prev_occ <= SKID - 2);
         chk("occ_bound", occ <= SKID, 1);
      end
      if (chain_read) begin
         chk("read_time", cyc_n, last_acc + DEPTH + 2);
         t = capq;
         t.sort();
         emitq.delete();
         for (int i = 0; i < t.size() && i < DEPTH; i++) emitq.push_back(t[i]);
         emitq.push_back('1);
      end
      if (u_out.vld) begin
         chk("out_extra", nout < E, 1);
         if (nout < E) begin
            chk("out_last", u_out.last, nout == E - 1);
            if (u_out.rdy) chk("out_conn", u_out.conn, expq[nout]);
         end
      end

      if (!chain_rst_n) capq.delete();
      else if (chain_vld) capq.push_back(chain_conn);
      pend_done = 1'b0;
      acc       = u_in.vld && u_in.rdy;
      prev_acc  = acc;
      prev_conn = u_in.conn;
      if (acc) begin
         void'(inq.pop_front());
         last_acc = cyc_n;
      end
      cur_occ = occ;
      if (chain_out_vld) begin
         void'(emitq.pop_front());
         if (in_drain && (npushed < E)) begin
            occ++;
            npushed++;
         end
      end
      if (u_out.vld && u_out.rdy) begin
         if (occ > 0) occ--;
         nout++;
         if (nout == E) begin
            pend_done = 1'b1;
            in_drain  = 1'b0;
         end
      end
      if (chain_read) in_drain = 1'b1;
      prev_occ = cur_occ;
      if (done) done_cnt++;
   endtask

   task automatic job(input int mode, input bit st_mid, input bit rst_mid);
      cv_t tq[$];
      int  s;
      bit  fin, sd_drain, aborted;
      n_job = inq.size();
      tq = inq;
      tq.sort();
      E = (n_job < DEPTH) ? n_job : DEPTH;
      expq.delete();
      for (int i = 0; i < E; i++) expq.push_back(tq[i]);
      rdy_mode = mode;
      nout = 0; npushed = 0; occ = 0; prev_occ = 0; done_cnt = 0;
      in_drain = 0; pend_done = 0; prev_acc = 0;
      emitq.delete();
      fin = 0; sd_drain = 0; aborted = 0;

      cyc(1'b1);
      s = cyc_n;
      chk("idle_busy", busy, 0);
      chk("idle_in_rdy", u_in.rdy, 0);
      for (int k = 0; k < 600 && !fin; k++) begin
         bit xs;
         xs = st_mid && ((cyc_n + 1 == s + 4) || (in_drain && !sd_drain));
         if (st_mid && in_drain) sd_drain = 1'b1;
         cyc(xs);
         if (cyc_n == s + 1) begin
            chk("busy_c1", busy, 1);
            chk("crst_c1", chain_rst_n, 0);
            chk("in_rdy_c1", u_in.rdy, 0);
         end
         if (cyc_n == s + 2) begin
            chk("crst_c2", chain_rst_n, 0);
            chk("in_rdy_c2", u_in.rdy, 0);
         end
         if (cyc_n == s + 3) begin
            chk("crst_c3", chain_rst_n, 1);
            chk("in_rdy_c3", u_in.rdy, 1);
         end
         if (done) fin = 1'b1;
         if (rst_mid && in_drain && (nout >= 1)) begin
            rst_n = 1'b0;
            #1;
            chk("rst_out_vld", u_out.vld, 0);
            chk("rst_crst", chain_rst_n, 0);
            chk("rst_busy", busy, 0);
            @(posedge clk);
            #1;
            rst_n   = 1'b1;
            aborted = 1'b1;
            fin     = 1'b1;
         end
      end
      if (!fin) chk("timeout", 0, 1);
      if (aborted) begin
         u_in.vld = 1'b0;
         start = 1'b0;
         chain_out_vld = 1'b0;
         inq.delete();
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
            chk("idle_after_rst", busy, 0);
            chk("no_out_after_rst", u_out.vld, 0);
         end
         chk("crst_idle", chain_rst_n, 1);
      end else begin
         chk("in_count", in_count, n_job);
         chk("n_results", nout, E);
         chk("done_busy", busy, 1);
         chk("done_cnt", done_cnt, 1);
      end
   endtask

   initial begin
      int n;
      u_in.vld = 1'b0; u_in.last = 1'b0; u_in.conn = '0; u_out.rdy = 1'b0;
      chain_out_conn = '0;
      repeat (2) @(negedge clk);
      chk("rst_crst", chain_rst_n, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_rdy", u_in.rdy, 0);
      chk("rst_chain_vld", chain_vld, 0);
      chk("rst_read", chain_read, 0);
      chk("rst_fwd", chain_fwd_rdy, 0);
      chk("rst_out_vld", u_out.vld, 0);
      chk("rst_out_last", u_out.last, 0);
      chk("rst_done", done, 0);
      chk("rst_in_count", in_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("crst_after_rst", chain_rst_n, 1);

      foreach (inq[i]) inq.delete(i);
      inq.push_back(mk(9)); inq.push_back(mk(3)); inq.push_back(mk(7));
      inq.push_back(mk(1)); inq.push_back(mk(5));
      job(0, 0, 0);

      inq.push_back(mk(8)); inq.push_back(mk(2));
      job(0, 0, 0);
      repeat (3) cyc(1'b0);

      inq.push_back(mk(6));
      job(0, 0, 0);

      for (int i = 0; i < 8; i++) inq.push_back(mk($urandom_range(0, 999)));
      job(1, 0, 0);

      for (int i = 0; i < 6; i++) inq.push_back(mk($urandom_range(0, 999)));
      job(2, 1, 0);

      for (int i = 0; i < 7; i++) inq.push_back(mk($urandom_range(0, 999)));
      job(2, 0, 1);

      for (int i = 0; i < 3; i++) inq.push_back(mk($urandom_range(0, 999)));
      job(0, 0, 0);

      for (int j = 0; j < 3; j++) begin
         n = $urandom_range(1, 9);
         for (int i = 0; i < n; i++) inq.push_back(mk($urandom_range(0, 500)));
         job($urandom_range(0, 2), 0, 0);
      end
      repeat (3) cyc(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule
